// File: rtl/mef_irrigacao_pkg.sv
// Shared state codes and width helper for the multi-zone irrigation controller.
package mef_irrigacao_pkg;

  typedef logic [2:0] estado_t;

  localparam estado_t DESLIGADO = 3'b000;
  localparam estado_t OCIOSO    = 3'b001;
  localparam estado_t ENCHENDO  = 3'b010;
  localparam estado_t SELECIONA = 3'b011;
  localparam estado_t REGANDO   = 3'b100;
  localparam estado_t ALARME    = 3'b101;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mef_irrigacao_multizona_arbitro_rr.sv
// Round-robin zone picker: first requesting zone after the last one served.
module arbitro_rr #(
  parameter int N  = 4,
  parameter int ZW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [ZW-1:0] ultima,
  output logic [ZW-1:0] grant,
  output logic          valid
);

  logic [ZW-1:0] cand;

  // k runs 1..N so the last-served zone is considered only after all others.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ZW'((int'(ultima) + k) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/mef_irrigacao_multizona.sv
// Multi-zone irrigation FSM: tank fill supervision plus round-robin zone watering.
module mef_irrigacao_multizona
  import mef_irrigacao_pkg::*;
#(
  parameter  int N_ZONAS     = 4,
  parameter  int T_REGA      = 16,
  parameter  int T_ENCHE_MAX = 64,
  localparam int ZW          = largura(N_ZONAS),
  localparam int RW          = largura(T_REGA),
  localparam int FW          = largura(T_ENCHE_MAX)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               nivel_baixo,
  input  logic               nivel_alto,
  input  logic               chuva,
  input  logic [N_ZONAS-1:0] seco,
  output logic [2:0]         estado,
  output logic               motor,
  output logic [N_ZONAS-1:0] ev,
  output logic [ZW-1:0]      zona,
  output logic               alarme
);

  localparam logic [FW-1:0] FILL_FIM   = FW'(T_ENCHE_MAX - 1);
  localparam logic [RW-1:0] REGA_FIM   = RW'(T_REGA - 1);
  localparam logic [ZW-1:0] ULTIMA_RST = ZW'(N_ZONAS - 1);

  estado_t       st_q, st_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [RW-1:0] rega_q, rega_d;
  logic [ZW-1:0] zona_q, zona_d, ultima_q, ultima_d;
  logic [ZW-1:0] grant;
  logic          grant_vld;

  arbitro_rr #(.N(N_ZONAS), .ZW(ZW)) u_arb (
    .req    (seco),
    .ultima (ultima_q),
    .grant  (grant),
    .valid  (grant_vld)
  );

  always_comb begin
    st_d     = st_q;
    fill_d   = fill_q;
    rega_d   = rega_q;
    zona_d   = zona_q;
    ultima_d = ultima_q;
    if (!start || st_q > ALARME) st_d = DESLIGADO;
    else if (st_q != DESLIGADO && nivel_baixo && nivel_alto) st_d = ALARME;
    else begin
      case (st_q)
        DESLIGADO: st_d = OCIOSO;
        OCIOSO: begin
          if (nivel_baixo) begin
            st_d   = ENCHENDO;
            fill_d = '0;
          end else if (!chuva && |seco) st_d = SELECIONA;
        end
        ENCHENDO: begin
          if (nivel_alto)              st_d = OCIOSO;
          else if (fill_q == FILL_FIM) st_d = ALARME;
          if (fill_q != FILL_FIM) fill_d = fill_q + 1'b1;
        end
        SELECIONA: begin
          if (grant_vld && !chuva) begin
            st_d   = REGANDO;
            zona_d = grant;
            rega_d = '0;
          end else st_d = OCIOSO;
        end
        REGANDO: begin
          if (rega_q == REGA_FIM || !seco[zona_q] || chuva || nivel_baixo) st_d = OCIOSO;
          if (rega_q != REGA_FIM) rega_d = rega_q + 1'b1;
        end
        default: st_d = ALARME;
      endcase
    end
    if (st_q == REGANDO && st_d != REGANDO) ultima_d = zona_q;
    // Shutdown is a clean restart: outputs all zero and rotation begins at zone 0.
    if (st_d == DESLIGADO) begin
      fill_d   = '0;
      rega_d   = '0;
      zona_d   = '0;
      ultima_d = ULTIMA_RST;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= DESLIGADO;
      fill_q   <= '0;
      rega_q   <= '0;
      zona_q   <= '0;
      ultima_q <= ULTIMA_RST;
    end else begin
      st_q     <= st_d;
      fill_q   <= fill_d;
      rega_q   <= rega_d;
      zona_q   <= zona_d;
      ultima_q <= ultima_d;
    end
  end

  always_comb begin
    ev = '0;
    if (st_q == REGANDO) ev[zona_q] = 1'b1;
  end

  assign estado = st_q;
  assign motor  = (st_q == ENCHENDO);
  assign zona   = zona_q;
  assign alarme = (st_q == ALARME);

endmodule

// File: tb/tb_mef_irrigacao_multizona.sv
// Bench for mef_irrigacao_multizona: directed scenarios plus random traffic vs a rule-level model.
module tb_mef_irrigacao_multizona;

  localparam int NZ = 4;
  localparam int TR = 16;
  localparam int TE = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          nivel_baixo = 1'b0;
  logic          nivel_alto = 1'b0;
  logic          chuva = 1'b0;
  logic [NZ-1:0] seco = '0;
  logic [2:0]    estado;
  logic          motor;
  logic [NZ-1:0] ev;
  logic [1:0]    zona;
  logic          alarme;

  int checks = 0;
  int errors = 0;

  // Model: 0 off, 1 idle, 2 filling, 3 selecting, 4 watering, 5 alarm.
  int m_st, m_fill, m_rega, m_zona, m_ult;

  always #5 clock = ~clock;

  mef_irrigacao_multizona #(.N_ZONAS(NZ), .T_REGA(TR), .T_ENCHE_MAX(TE)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .nivel_baixo (nivel_baixo),
    .nivel_alto  (nivel_alto),
    .chuva       (chuva),
    .seco        (seco),
    .estado      (estado),
    .motor       (motor),
    .ev          (ev),
    .zona        (zona),
    .alarme      (alarme)
  );

  function automatic void model_reset();
    m_st = 0; m_fill = 0; m_rega = 0; m_zona = 0; m_ult = NZ - 1;
  endfunction

  function automatic void model_step();
    int nx;
    bit found;
    nx = m_st;
    found = 0;
    if (!start) nx = 0;
    else if (m_st != 0 && nivel_baixo && nivel_alto) nx = 5;
    else begin
      case (m_st)
        0: nx = 1;
        1: if (nivel_baixo) begin nx = 2; m_fill = 0; end
           else if (!chuva && seco != 0) nx = 3;
        2: if (nivel_alto) nx = 1;
           else if (m_fill == TE - 1) nx = 5;
           else m_fill++;
        3: begin
          if (!chuva)
            for (int k = 1; k <= NZ && !found; k++)
              if (seco[(m_ult + k) % NZ]) begin found = 1; m_zona = (m_ult + k) % NZ; end
          if (found) begin nx = 4; m_rega = 0; end else nx = 1;
        end
        4: if (m_rega == TR - 1 || !seco[m_zona] || chuva || nivel_baixo) nx = 1;
           else m_rega++;
        default: nx = 5;
      endcase
    end
    if (m_st == 4 && nx != 4) m_ult = m_zona;
    if (nx == 0) begin m_zona = 0; m_ult = NZ - 1; end
    m_st = nx;
  endfunction

  function automatic logic [10:0] exp_out();
    logic [NZ-1:0] e;
    e = '0;
    if (m_st == 4) e[m_zona] = 1'b1;
    return {3'(m_st), m_st == 2, e, 2'(m_zona), m_st == 5};
  endfunction

  always @(posedge clock or negedge reset_n)
    if (!reset_n) model_reset();
    else model_step();

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic go_idle();
    start = 0; nivel_baixo = 0; nivel_alto = 0; chuva = 0; seco = '0;
    tick();
    start = 1;
    tick();
  endtask

  task automatic wait_regando(output bit ok);
    int n = 0;
    while (estado !== 3'd4 && n < 20) begin tick(); n++; end
    ok = (estado === 3'd4);
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 0; start = 0; nivel_baixo = 0; nivel_alto = 0; chuva = 0; seco = '0;
    #3;
    checks++;
    if ({estado, motor, ev, zona, alarme} !== 11'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", {estado, motor, ev, zona, alarme}, 11'b0);
    end
    @(negedge clock);
    reset_n = 1; start = 1;
    checks++;
    if (estado !== 3'b000) begin errors++; $display("FAIL reset_desligado got=%b exp=000", estado); end
    tick();
    checks++;
    if (estado !== 3'b001) begin errors++; $display("FAIL reset_to_ocioso got=%b exp=001", estado); end
    checks++;
    if ({estado, motor, ev, zona, alarme} !== exp_out()) begin
      errors++; $display("FAIL reset_ocioso_outs got=%b exp=%b", {estado, motor, ev, zona, alarme}, exp_out());
    end
  endtask

  task automatic test_round_robin();
    logic [NZ-1:0] run_ev[$];
    int run_len[$];
    logic [NZ-1:0] prev;
    go_idle();
    seco = 4'b1010;
    prev = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if ({estado, motor, ev, zona, alarme} !== exp_out()) begin
        errors++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", c, {estado, motor, ev, zona, alarme}, exp_out());
      end
      if (ev != 0) begin
        if (ev == prev) run_len[run_len.size() - 1]++;
        else begin run_ev.push_back(ev); run_len.push_back(1); end
      end
      prev = ev;
    end
    checks++;
    if (run_ev.size() < 3) begin
      errors++; $display("FAIL rr_runs got=%0d exp>=3", run_ev.size());
    end else begin
      checks++;
      if (run_ev[0] !== 4'b0010 || run_len[0] != 16) begin
        errors++; $display("FAIL rr_first got=%b/%0d exp=0010/16", run_ev[0], run_len[0]);
      end
      checks++;
      if (run_ev[1] !== 4'b1000 || run_len[1] != 16) begin
        errors++; $display("FAIL rr_second got=%b/%0d exp=1000/16", run_ev[1], run_len[1]);
      end
      checks++;
      if (run_ev[2] !== 4'b0010) begin
        errors++; $display("FAIL rr_third got=%b exp=0010", run_ev[2]);
      end
    end
  endtask

  task automatic test_fill_timeout();
    int mcnt = 0;
    int n = 0;
    go_idle();
    nivel_baixo = 1;
    while (alarme !== 1'b1 && n < 200) begin
      tick(); n++;
      if (motor === 1'b1) mcnt++;
    end
    checks++;
    if (alarme !== 1'b1 || mcnt != TE) begin
      errors++; $display("FAIL fill_timeout motor_cycles=%0d alarme=%b exp=%0d/1", mcnt, alarme, TE);
    end
    nivel_baixo = 0; nivel_alto = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (alarme !== 1'b1 || estado !== 3'b101 || motor !== 1'b0) begin
        errors++; $display("FAIL alarm_latched alarme=%b estado=%b motor=%b exp=1/101/0", alarme, estado, motor);
      end
    end
    start = 0;
    tick();
    checks++;
    if (estado !== 3'b000 || alarme !== 1'b0) begin
      errors++; $display("FAIL alarm_clear estado=%b alarme=%b exp=000/0", estado, alarme);
    end
  endtask

  task automatic test_rain();
    bit ok;
    go_idle();
    seco = 4'b0100;
    wait_regando(ok);
    checks++;
    if (!ok || ev !== 4'b0100) begin
      errors++; $display("FAIL rain_enter estado=%b ev=%b exp=100/0100", estado, ev);
    end
    repeat (4) tick();
    chuva = 1;
    tick();
    checks++;
    if (ev !== 4'b0000 || estado !== 3'b001) begin
      errors++; $display("FAIL rain_stop ev=%b estado=%b exp=0000/001", ev, estado);
    end
    chuva = 0; seco = '0;
  endtask

  task automatic test_alarm_regando();
    bit ok;
    go_idle();
    seco = 4'b0001;
    wait_regando(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alarm_reg_enter estado=%b exp=100", estado); end
    repeat (3) tick();
    nivel_baixo = 1; nivel_alto = 1;
    tick();
    checks++;
    if (estado !== 3'b101 || alarme !== 1'b1 || ev !== 4'b0) begin
      errors++; $display("FAIL alarm_reg estado=%b alarme=%b ev=%b exp=101/1/0000", estado, alarme, ev);
    end
    start = 0;
    tick();
    checks++;
    if (estado !== 3'b000 || alarme !== 1'b0) begin
      errors++; $display("FAIL alarm_reg_off estado=%b alarme=%b exp=000/0", estado, alarme);
    end
    nivel_baixo = 0; nivel_alto = 0;
  endtask

  task automatic test_async_reset();
    bit ok;
    go_idle();
    seco = 4'b1000;
    wait_regando(ok);
    checks++;
    if (!ok || ev !== 4'b1000) begin errors++; $display("FAIL areset_enter estado=%b ev=%b exp=100/1000", estado, ev); end
    repeat (2) tick();
    #2 reset_n = 0;
    #1;
    checks++;
    if (estado !== 3'b000 || ev !== 4'b0 || {motor, zona, alarme} !== 4'b0) begin
      errors++; $display("FAIL areset_immediate estado=%b ev=%b exp=000/0000", estado, ev);
    end
    @(negedge clock);
    reset_n = 1;
    tick();
    checks++;
    if ({estado, motor, ev, zona, alarme} !== exp_out() || estado !== 3'b001) begin
      errors++; $display("FAIL areset_restart got=%b exp=%b", {estado, motor, ev, zona, alarme}, exp_out());
    end
  endtask

  task automatic test_random();
    bit seco_dry_tank;
    go_idle();
    seco_dry_tank = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) seco_dry_tank = ($urandom_range(0, 2) == 0);
      start       = ($urandom_range(0, 149) != 0);
      nivel_baixo = ($urandom_range(0, 14) == 0) || (seco_dry_tank && $urandom_range(0, 1) == 0);
      nivel_alto  = seco_dry_tank ? 1'b0 : ($urandom_range(0, 5) == 0);
      chuva       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) seco = NZ'($urandom);
      tick();
      checks++;
      if ({estado, motor, ev, zona, alarme} !== exp_out()) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, {estado, motor, ev, zona, alarme}, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fill_timeout();
    test_rain();
    test_alarm_regando();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mef_irrigacao_multizona.md
MEF_IRRIGACAO_MULTIZONA -- requirements
Module: mef_irrigacao_multizona

Interface
REQ-001 Parameter N_ZONAS, default 4, number of irrigation zones (legal 1..8).
REQ-002 Parameter T_REGA, default 16, maximum watering cycles per zone turn (legal 2..255).
REQ-003 Parameter T_ENCHE_MAX, default 64, tank-fill timeout in cycles (legal 2..1023).
REQ-004 clock  in  1  single system clock, all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  system enable; 0 forces shutdown.
REQ-007 nivel_baixo  in  1  tank level below minimum.
REQ-008 nivel_alto  in  1  tank full.
REQ-009 chuva  in  1  rain detected; inhibits watering.
REQ-010 seco  in  N_ZONAS  per-zone dry-soil request.
REQ-011 estado  out  3  current state code.
REQ-012 motor  out  1  fill pump on.
REQ-013 ev  out  N_ZONAS  zone valves, at most one bit set.
REQ-014 zona  out  clog2(N_ZONAS) (min 1)  index of zone being watered.
REQ-015 alarme  out  1  fault indication.

Function
REQ-016 States/codes: DESLIGADO 000, OCIOSO 001, ENCHENDO 010, SELECIONA 011, REGANDO 100, ALARME 101; codes 110/111 SHALL go to DESLIGADO next cycle.
REQ-017 Outputs SHALL be Moore, decoded only from registered state, zona and counters; no combinational input-to-output path.
REQ-018 Priority each cycle: start=0 -> DESLIGADO; else nivel_baixo=1 and nivel_alto=1 in any state except DESLIGADO -> ALARME; else per-state rules below.
REQ-019 DESLIGADO: all outputs 0; start=1 -> OCIOSO.
REQ-020 OCIOSO: nivel_baixo=1 -> ENCHENDO; else chuva=0 and seco!=0 -> SELECIONA; else hold.
REQ-021 ENCHENDO: motor=1; fill counter cleared on entry, +1 per cycle; nivel_alto=1 -> OCIOSO; counter = T_ENCHE_MAX-1 with nivel_alto=0 -> ALARME (timeout wins over nothing else same cycle).
REQ-022 SELECIONA (one cycle): round-robin search starting at ultima+1 (mod N_ZONAS) for first seco bit; found -> latch zona, clear rega counter, -> REGANDO; none or chuva=1 -> OCIOSO.
REQ-023 REGANDO: ev[zona]=1, motor=0; rega counter +1 per cycle; exit to OCIOSO when counter = T_REGA-1, or seco[zona]=0, or chuva=1, or nivel_baixo=1; on exit ultima <= zona.
REQ-024 ALARME: alarme=1, motor=0, ev=0; latched until start=0.
REQ-025 estado SHALL equal state code; zona holds last latched value outside REGANDO; ev=0 outside REGANDO.
REQ-026 Counters SHALL saturate, never wrap; widths clog2 of their parameter.
REQ-027 seco changes during REGANDO for other zones SHALL NOT change zona.

Reset
REQ-028 reset_n=0 SHALL asynchronously force DESLIGADO, counters 0, zona 0, ultima N_ZONAS-1, all outputs 0.
REQ-029 Reset release mid-operation SHALL restart from DESLIGADO; no state retained.

Structure
REQ-030 State codes and state typedef SHALL live in shared package mef_irrigacao_pkg.
REQ-031 Round-robin selection SHALL be one sub-module arbitro_rr (inputs req, ultima; outputs grant index, valid).
REQ-032 Target 120-400 lines of RTL.

Verification
REQ-033 Reset, start=1, all sensors 0, seco=0 -> DESLIGADO then OCIOSO after 1 clock, outputs 0.
REQ-034 N_ZONAS=4, seco=4'b1010, chuva=0 -> zone 1 watered T_REGA=16 cycles (ev=0010), then zone 3 (ev=1000), then zone 1 again.
REQ-035 nivel_baixo=1 in OCIOSO, nivel_alto never 1 -> motor=1 for 64 cycles, then ALARME, alarme=1 until start=0.
REQ-036 chuva=1 on cycle 5 of REGANDO -> ev=0 next cycle, estado=001.
REQ-037 nivel_baixo=1 and nivel_alto=1 during REGANDO -> ALARME next cycle; start=0 -> DESLIGADO.
REQ-038 reset_n=0 asserted mid-REGANDO between edges -> ev=0, estado=000 immediately, no clock required.
